// File: rtl/vx_tcu_drl_norm_sched.sv
// Shares one combinational FEDP normalize/round unit among NUM_REQS accumulator lanes.
// Optional build macro TCU_NORM_RR_ARB_EN selects round-robin arbitration (default: fixed priority).
module vx_tcu_drl_norm_sched #(
  parameter int NUM_REQS = 4,
  parameter int DATA_W   = 64,
  parameter int TAG_W    = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           req_valid,
  output logic [NUM_REQS-1:0]           req_ready,
  input  logic [NUM_REQS*DATA_W-1:0]    req_data,
  input  logic [NUM_REQS*TAG_W-1:0]     req_tag,
  output logic                          nr_valid,
  output logic [DATA_W-1:0]             nr_data,
  output logic [TAG_W-1:0]              nr_tag,
  input  logic [31:0]                   nr_result,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [31:0]                   rsp_result,
  output logic [TAG_W-1:0]              rsp_tag,
  output logic [$clog2(NUM_REQS)-1:0]   rsp_lane,
  input  logic                          flush_req,
  output logic                          flush_done
);

  localparam int LANE_W = $clog2(NUM_REQS);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]          state;
  logic [NUM_REQS-1:0] grant;
  logic [LANE_W-1:0]   grant_lane;
  logic                any_grant;
  logic                s0_en;
  logic                s1_en;
  logic                can_issue;
  logic                xfer;
  logic [LANE_W-1:0]   nr_lane;

`ifdef TCU_NORM_RR_ARB_EN
  logic [LANE_W-1:0]   rr_ptr;
`endif

  assign s1_en = !rsp_valid || rsp_ready;
  assign s0_en = !nr_valid || s1_en;

  // A flush request seen in RUN already blocks the grant of that same cycle.
  assign can_issue = (state == ST_RUN) && !flush_req && s0_en;
  assign req_ready = grant & {NUM_REQS{can_issue}};
  assign xfer      = any_grant && can_issue;

  always_comb begin : grant_sel
    int unsigned idx;
    idx        = 0;
    grant      = '0;
    grant_lane = '0;
    any_grant  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQS; k++) begin
`ifdef TCU_NORM_RR_ARB_EN
      idx = (int unsigned'(rr_ptr) + k) % NUM_REQS;
`else
      idx = k;
`endif
      if (!any_grant && req_valid[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_lane = LANE_W'(idx);
      end
    end
  end

`ifdef TCU_NORM_RR_ARB_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (grant_lane == LANE_W'(NUM_REQS - 1)) ? '0 : grant_lane + 1'b1;
    end
  end
`endif

  // Issue stage: drives the shared unit directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      nr_valid <= 1'b0;
      nr_data  <= '0;
      nr_tag   <= '0;
      nr_lane  <= '0;
    end else if (xfer) begin
      nr_valid <= 1'b1;
      nr_data  <= req_data[grant_lane*DATA_W +: DATA_W];
      nr_tag   <= req_tag[grant_lane*TAG_W +: TAG_W];
      nr_lane  <= grant_lane;
    end else if (s1_en) begin
      nr_valid <= 1'b0;
    end
  end

  // Output stage: captures the unit result alongside its id and source lane.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_tag    <= '0;
      rsp_lane   <= '0;
    end else if (s1_en && nr_valid) begin
      rsp_valid  <= 1'b1;
      rsp_result <= nr_result;
      rsp_tag    <= nr_tag;
      rsp_lane   <= nr_lane;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:   if (flush_req) state <= ST_DRAIN;
        ST_DRAIN: if (!nr_valid && !rsp_valid) state <= ST_DONE;
        ST_DONE:  if (!flush_req) state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

  assign flush_done = (state == ST_DONE);

endmodule

// File: tb/tb_vx_tcu_drl_norm_sched.sv
// Randomized and directed bench for vx_tcu_drl_norm_sched against a queue-based reference model.
module tb_vx_tcu_drl_norm_sched;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int TW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*DW-1:0]   req_data;
  logic [N*TW-1:0]   req_tag;
  logic              nr_valid;
  logic [DW-1:0]     nr_data;
  logic [TW-1:0]     nr_tag;
  logic [31:0]       nr_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_result;
  logic [TW-1:0]     rsp_tag;
  logic [1:0]        rsp_lane;
  logic              flush_req;
  logic              flush_done;

  vx_tcu_drl_norm_sched #(.NUM_REQS(N), .DATA_W(DW), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_tag(req_tag),
    .nr_valid(nr_valid), .nr_data(nr_data), .nr_tag(nr_tag), .nr_result(nr_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_lane(rsp_lane),
    .flush_req(flush_req), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared normalize unit.
  logic force_res = 1'b0;
  function automatic logic [31:0] unit_fn(input logic [63:0] d);
    return force_res ? 32'h3F800000 : (d[63:32] ^ {d[15:0], d[31:16]});
  endfunction
  always_comb nr_result = unit_fn(nr_data);

  typedef struct {
    logic [31:0] res;
    logic [31:0] tag;
    int          lane;
    int          age;
  } ent_t;

  ent_t q[$];
  int   mstate;   // 0 run, 1 drain, 2 done
  int   mptr;
  int   n_cmp = 0;
  int   n_err = 0;
  logic fix_tag2 = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int lane;
`ifdef TCU_NORM_RR_ARB_EN
      lane = (mptr + k) % N;
`else
      lane = k;
`endif
      if (v[lane]) return lane;
    end
    return -1;
  endfunction

  task automatic step(input logic [N-1:0] v, input logic rr, input logic fl);
    int   g;
    bit   allow, pop, acc, exp_nrv, exp_rspv;
    logic [N-1:0] exp_ready;
    ent_t e;
    @(negedge clk);
    reset     = 1'b0;
    req_valid = v;
    rsp_ready = rr;
    flush_req = fl;
    for (int i = 0; i < N * DW / 32; i++) req_data[i*32 +: 32] = $urandom();
    for (int i = 0; i < N; i++) req_tag[i*TW +: TW] = $urandom();
    if (fix_tag2) req_tag[2*TW +: TW] = 32'h11;
    #1;
    g        = model_grant(v);
    allow    = (mstate == 0) && !fl && (q.size() < 2 || rr);
    acc      = allow && (g >= 0);
    exp_ready = acc ? (N'(1) << g) : '0;
    exp_nrv  = (q.size() == 2) || (q.size() == 1 && q[0].age == 0);
    exp_rspv = (q.size() > 0) && (q[0].age >= 1);
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("nr_valid", 64'(nr_valid), 64'(exp_nrv));
    if (exp_nrv) chk("nr_tag", 64'(nr_tag), 64'(q[q.size()-1].tag));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rspv));
    if (exp_rspv) begin
      chk("rsp_result", 64'(rsp_result), 64'(q[0].res));
      chk("rsp_tag", 64'(rsp_tag), 64'(q[0].tag));
      chk("rsp_lane", 64'(rsp_lane), 64'(q[0].lane));
    end
    chk("flush_done", 64'(flush_done), 64'(mstate == 2));
    // advance the model to the state after the coming edge
    pop = exp_rspv && rr;
    case (mstate)
      0: if (fl) mstate = 1;
      1: if (q.size() == 0) mstate = 2;
      default: if (!fl) mstate = 0;
    endcase
    if (pop) void'(q.pop_front());
    foreach (q[i]) q[i].age++;
    if (acc) begin
      e.res  = unit_fn(req_data[g*DW +: DW]);
      e.tag  = req_tag[g*TW +: TW];
      e.lane = g;
      e.age  = 0;
      q.push_back(e);
      mptr = (g + 1) % N;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = N'($urandom());
    rsp_ready = 1'b0;
    flush_req = 1'b0;
    @(posedge clk);
    q.delete();
    mstate = 0;
    mptr   = 0;
  endtask

  int   cnt;
  logic fl_r;

  initial begin
    reset = 1'b1; req_valid = '0; rsp_ready = 1'b0; flush_req = 1'b0;
    req_data = '0; req_tag = '0;
    q.delete(); mstate = 0; mptr = 0;
    repeat (2) @(posedge clk);

    // Reset state.
    step('0, 1'b1, 1'b0);

    // Single request from lane 2 with a fixed unit result.
    force_res = 1'b1; fix_tag2 = 1'b1;
    step(4'b0100, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    chk("single_valid", 64'(rsp_valid), 64'd1);
    chk("single_result", 64'(rsp_result), 64'h3F800000);
    chk("single_tag", 64'(rsp_tag), 64'h11);
    chk("single_lane", 64'(rsp_lane), 64'd2);
    step('0, 1'b1, 1'b0);
    force_res = 1'b0; fix_tag2 = 1'b0;

    // Contention right after reset so the pointer starts at lane 0.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(4'hF, 1'b1, 1'b0);
`ifdef TCU_NORM_RR_ARB_EN
      chk("contend_grant", 64'(req_ready), 64'(4'b0001 << (i % 4)));
`else
      chk("contend_grant", 64'(req_ready), 64'h1);
`endif
    end
    repeat (3) step('0, 1'b1, 1'b0);

    // Backpressure: only S0 and S1 can fill.
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(4'hF, 1'b0, 1'b0);
      if (|req_ready) cnt++;
    end
    chk("bp_accepted", 64'(cnt), 64'd2);
    repeat (3) step('0, 1'b1, 1'b0);

    // Flush with both stages full.
    step(4'hF, 1'b0, 1'b0);
    step(4'hF, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(4'hF, 1'b1, 1'b1);
      if (rsp_valid) cnt++;
    end
    chk("flush_rsps", 64'(cnt), 64'd2);
    chk("flush_done_hi", 64'(flush_done), 64'd1);
    step(4'hF, 1'b1, 1'b0);
    step(4'hF, 1'b1, 1'b0);
    chk("resume_accept", 64'(|req_ready), 64'd1);
    repeat (3) step('0, 1'b1, 1'b0);

    // Reset with both stages valid.
    step(4'hF, 1'b0, 1'b0);
    step(4'hF, 1'b0, 1'b0);
    do_reset();
    step('0, 1'b1, 1'b0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_nr_valid", 64'(nr_valid), 64'd0);

    // Flush and request in the same RUN cycle.
    step(4'b0001, 1'b1, 1'b1);
    chk("flush_req_block", 64'(req_ready), 64'd0);
    repeat (3) step(4'b0001, 1'b1, 1'b1);
    step(4'b0001, 1'b1, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    chk("flush_req_after", 64'(req_ready), 64'd1);
    repeat (3) step('0, 1'b1, 1'b0);

    // Randomized traffic with occasional flushes and resets.
    fl_r = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
        fl_r = 1'b0;
      end else begin
        if ($urandom_range(0, 24) == 0) fl_r = !fl_r;
        step(N'($urandom()), $urandom_range(0, 3) != 0, fl_r);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
